// File: rtl/boot_loader.sv
// -----------------------------------------------------------------------------
// boot_loader
//
// Loads a program image into instruction memory before the core is released
// from reset. The loader receives a byte stream over a valid/ready handshake
// and packs it into little-endian 32-bit words. Each finished word is written
// through a dedicated instruction-memory write port. The core is held in reset
// until the last word has been written.
//
// Parameters
//   ADDR_W     word-address width of the instruction-memory write port
//   TIMEOUT    consecutive receive cycles without an accepted byte before the
//              load aborts (must be >= 2)
//
// Ports
//   CLK        system clock, rising edge
//   RST        asynchronous active-high reset
//   start      one-cycle load request; word_count is sampled with it
//   word_count number of 32-bit words to load (1 .. 2^ADDR_W-1)
//   rx_valid   rx_data carries a byte
//   rx_data    stream byte
//   rx_ready   loader accepts a byte this cycle (RECV only)
//   we         instruction-memory write enable (one cycle per word)
//   waddr      word write address (holds its last value outside WRITE)
//   wdata      write data (holds its last value outside WRITE)
//   core_rst   reset to the core; low only while running
//   busy       load in progress
//   done       program loaded, core running
//   err        load aborted (zero count or timeout)
// -----------------------------------------------------------------------------
module boot_loader #(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 1024
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              start,
   input  logic [ADDR_W-1:0] word_count,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [31:0]       wdata,
   output logic              core_rst,
   output logic              busy,
   output logic              done,
   output logic              err
);

   // The timer only has to count up to TIMEOUT-1, so this width never wraps.
   localparam int                 TMR_W    = $clog2(TIMEOUT + 1);
   localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic [TMR_W-1:0]   TMR_ONE  = TMR_W'(1);
   localparam logic [ADDR_W-1:0]  ADDR_ONE = ADDR_W'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RECV  = 3'd1,
      S_WRITE = 3'd2,
      S_RUN   = 3'd3,
      S_ERR   = 3'd4
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] count_q, count_d;
   logic [ADDR_W-1:0] idx_q,   idx_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [1:0]        byte_q,  byte_d;
   logic [23:0]       part_q,  part_d;   // bytes 0..2 of the word being built
   logic [31:0]       wdata_q, wdata_d;
   logic [TMR_W-1:0]  timer_q, timer_d;

   logic accept_s;
   logic start_ok_s;

   assign accept_s   = (state_q == S_RECV) && rx_valid;
   assign start_ok_s = start && (word_count != {ADDR_W{1'b0}});

   // Next-state and datapath update for the load sequencer.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      idx_d   = idx_q;
      waddr_d = waddr_q;
      byte_d  = byte_q;
      part_d  = part_q;
      wdata_d = wdata_q;
      timer_d = timer_q;

      case (state_q)
         S_IDLE, S_RUN, S_ERR: begin
            if (start_ok_s) begin
               state_d = S_RECV;
               count_d = word_count;
               idx_d   = {ADDR_W{1'b0}};
               byte_d  = 2'd0;
               timer_d = {TMR_W{1'b0}};
            end else if (start) begin
               // A zero word count can never produce a bootable image.
               state_d = S_ERR;
            end else begin
               state_d = state_q;
            end
         end

         S_RECV: begin
            // An accept always wins, even on the cycle the timer expires.
            if (accept_s) begin
               timer_d = {TMR_W{1'b0}};
               case (byte_q)
                  2'd0: begin
                     part_d[7:0] = rx_data;
                     byte_d      = 2'd1;
                  end
                  2'd1: begin
                     part_d[15:8] = rx_data;
                     byte_d       = 2'd2;
                  end
                  2'd2: begin
                     part_d[23:16] = rx_data;
                     byte_d        = 2'd3;
                  end
                  default: begin
                     // Fourth byte completes the word; present it to memory.
                     wdata_d = {rx_data, part_q};
                     waddr_d = idx_q;
                     byte_d  = 2'd0;
                     state_d = S_WRITE;
                  end
               endcase
            end else if (timer_q == TMR_LAST) begin
               state_d = S_ERR;
            end else begin
               timer_d = timer_q + TMR_ONE;
            end
         end

         S_WRITE: begin
            timer_d = {TMR_W{1'b0}};
            if (idx_q == (count_q - ADDR_ONE)) begin
               state_d = S_RUN;
            end else begin
               idx_d   = idx_q + ADDR_ONE;
               state_d = S_RECV;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Sequencer and datapath registers; reset discards any partial word.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         count_q <= {ADDR_W{1'b0}};
         idx_q   <= {ADDR_W{1'b0}};
         waddr_q <= {ADDR_W{1'b0}};
         byte_q  <= 2'd0;
         part_q  <= 24'd0;
         wdata_q <= 32'd0;
         timer_q <= {TMR_W{1'b0}};
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         idx_q   <= idx_d;
         waddr_q <= waddr_d;
         byte_q  <= byte_d;
         part_q  <= part_d;
         wdata_q <= wdata_d;
         timer_q <= timer_d;
      end
   end

   // Control outputs are pure decodes of the state register.
   assign rx_ready = (state_q == S_RECV);
   assign we       = (state_q == S_WRITE);
   assign busy     = (state_q == S_RECV) || (state_q == S_WRITE);
   assign done     = (state_q == S_RUN);
   assign err      = (state_q == S_ERR);
   assign core_rst = (state_q != S_RUN);
   assign waddr    = waddr_q;
   assign wdata    = wdata_q;

endmodule

// File: tb/tb_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_boot_loader
//
// Self-checking bench for boot_loader. Stimulus byte streams and handshake
// gaps are drawn with $urandom (plus the directed streams of the test plan).
// Expected results come from a transaction-level model: the expected memory
// image is assembled from the byte list with plain arithmetic, and the
// expected timing follows from "5 cycles per word plus one per idle receive
// cycle" and "abort TIMEOUT cycles after the last accept".
//
// Cycle bookkeeping: edge_cnt counts rising edges. A value sampled on the
// falling edge belongs to the cycle that follows rising edge edge_cnt.
// -----------------------------------------------------------------------------
module tb_boot_loader;

   localparam int ADDR_W  = 8;
   localparam int TIMEOUT = 16;

   logic              CLK = 1'b0;
   logic              RST;
   logic              start;
   logic [ADDR_W-1:0] word_count;
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              rx_ready;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [31:0]       wdata;
   logic              core_rst;
   logic              busy;
   logic              done;
   logic              err;

   int n_checks = 0;
   int n_fail   = 0;
   int edge_cnt = 0;

   logic [7:0]  bytes[$];
   int          gap_plan[$];
   int          wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   int          wr_edge_q[$];
   logic [7:0]  dir_bytes[8] = '{8'h13, 8'h01, 8'h10, 8'h00, 8'h33, 8'h03, 8'h03, 8'h00};

   boot_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .start      (start),
      .word_count (word_count),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .we         (we),
      .waddr      (waddr),
      .wdata      (wdata),
      .core_rst   (core_rst),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) edge_cnt <= edge_cnt + 1;

   // Memory-side monitor: log every write pulse.
   always @(negedge CLK) begin
      if (we === 1'b1) begin
         wr_addr_q.push_back(int'(waddr));
         wr_data_q.push_back(wdata);
         wr_edge_q.push_back(edge_cnt);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_log();
      wr_addr_q.delete();
      wr_data_q.delete();
      wr_edge_q.delete();
   endtask

   // Build the byte stream and the idle gap before each byte. A gap never
   // precedes the first byte of a later word, so every gap cycle lands in RECV.
   task automatic set_stream(input int nb, input bit directed, input int max_gap);
      bytes.delete();
      gap_plan.delete();
      for (int j = 0; j < nb; j++) begin
         bytes.push_back(directed ? dir_bytes[j % 8] : 8'($urandom));
         if ((j % 4) == 0 && j > 0) gap_plan.push_back(0);
         else gap_plan.push_back(int'($urandom_range(0, max_gap)));
      end
   endtask

   // Pulse start; returns on the falling edge after the sampling edge.
   task automatic do_start(input logic [ADDR_W-1:0] cnt, output int s_edge);
      @(negedge CLK);
      start      = 1'b1;
      word_count = cnt;
      s_edge     = edge_cnt + 1;
      @(negedge CLK);
      start      = 1'b0;
      word_count = ADDR_W'($urandom);
   endtask

   // Source side of the handshake; returns on the falling edge after the last accept.
   task automatic feed(input int nb, output int stalls);
      int   idx;
      int   gap;
      logic acc;
      idx    = 0;
      stalls = 0;
      gap    = gap_plan[0];
      for (int c = 0; c < 2000 && idx < nb; c++) begin
         if (gap > 0) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            gap--;
            stalls++;
         end else begin
            rx_valid = 1'b1;
            rx_data  = bytes[idx];
         end
         acc = rx_valid && rx_ready;
         @(negedge CLK);
         if (acc) begin
            idx++;
            if (idx < nb) gap = gap_plan[idx];
         end
      end
      rx_valid = 1'b0;
      check("feed_all_bytes", 32'(idx), 32'(nb));
   endtask

   // Full load of n words from the current bytes/gap_plan, checked against the model.
   task automatic load_and_check(input int n, input string tag);
      int          s;
      int          stalls;
      int          fall_edge;
      logic [31:0] exp_word;
      clear_log();
      do_start(ADDR_W'(n), s);
      check({tag, "_busy_after_start"},     32'(busy),     32'd1);
      check({tag, "_ready_after_start"},    32'(rx_ready), 32'd1);
      check({tag, "_corerst_after_start"},  32'(core_rst), 32'd1);
      check({tag, "_done_after_start"},     32'(done),     32'd0);
      check({tag, "_err_after_start"},      32'(err),      32'd0);
      feed(4 * n, stalls);
      fall_edge = -1;
      for (int c = 0; c < 10 && fall_edge < 0; c++) begin
         if (core_rst === 1'b0) fall_edge = edge_cnt;
         else @(negedge CLK);
      end
      // core_rst low in cycle start+5N+1+stalls, i.e. the one after edge start+5N+stalls.
      check({tag, "_corerst_fall_edge"}, 32'(fall_edge), 32'(s + 5 * n + stalls));
      check({tag, "_write_count"}, 32'(wr_addr_q.size()), 32'(n));
      for (int k = 0; k < n && k < wr_addr_q.size(); k++) begin
         exp_word = 32'(bytes[4*k]) | (32'(bytes[4*k+1]) << 8)
                  | (32'(bytes[4*k+2]) << 16) | (32'(bytes[4*k+3]) << 24);
         check({tag, "_waddr"}, 32'(wr_addr_q[k]), 32'(k));
         check({tag, "_wdata"}, wr_data_q[k], exp_word);
      end
      if (wr_edge_q.size() > 0)
         check({tag, "_last_we_edge"}, 32'(wr_edge_q[wr_edge_q.size()-1]), 32'(s + 5 * n + stalls - 1));
      check({tag, "_done"},     32'(done),     32'd1);
      check({tag, "_err"},      32'(err),      32'd0);
      check({tag, "_busy_end"}, 32'(busy),     32'd0);
      check({tag, "_ready_run"},32'(rx_ready), 32'd0);
      // Bytes offered while running must be ignored.
      for (int c = 0; c < 3; c++) begin
         rx_valid = 1'b1;
         rx_data  = 8'($urandom);
         @(negedge CLK);
      end
      rx_valid = 1'b0;
      check({tag, "_no_write_in_run"}, 32'(wr_addr_q.size()), 32'(n));
      check({tag, "_done_holds"},      32'(done),             32'd1);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
      check({tag, "_we"},       32'(we),       32'd0);
      check({tag, "_waddr"},    32'(waddr),    32'd0);
      check({tag, "_wdata"},    wdata,         32'd0);
      check({tag, "_core_rst"}, 32'(core_rst), 32'd1);
      check({tag, "_busy"},     32'(busy),     32'd0);
      check({tag, "_done"},     32'(done),     32'd0);
      check({tag, "_err"},      32'(err),      32'd0);
   endtask

   // Zero-count start: ERR next cycle, core held, nothing written.
   task automatic zero_count(input string tag);
      int s;
      clear_log();
      do_start({ADDR_W{1'b0}}, s);
      check({tag, "_err"},      32'(err),      32'd1);
      check({tag, "_core_rst"}, 32'(core_rst), 32'd1);
      check({tag, "_done"},     32'(done),     32'd0);
      check({tag, "_ready"},    32'(rx_ready), 32'd0);
      repeat (3) @(negedge CLK);
      check({tag, "_no_write"}, 32'(wr_addr_q.size()), 32'd0);
      check({tag, "_err_hold"}, 32'(err),      32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      int stalls;
      int err_edge;
      int n_words;

      RST        = 1'b1;
      start      = 1'b0;
      word_count = {ADDR_W{1'b0}};
      rx_valid   = 1'b0;
      rx_data    = 8'd0;
      repeat (3) @(negedge CLK);
      check_reset_values("in_reset");
      RST = 1'b0;
      @(negedge CLK);
      check_reset_values("after_reset");

      // Directed two-word image at full rate.
      set_stream(8, 1'b1, 0);
      load_and_check(2, "dir_full");
      if (wr_data_q.size() == 2) begin
         check("dir_word0", wr_data_q[0], 32'h00100113);
         check("dir_word1", wr_data_q[1], 32'h00030333);
      end

      // Same image with a 3-cycle hole between bytes 2 and 3 (reload from RUN).
      set_stream(8, 1'b1, 0);
      gap_plan[2] = 3;
      load_and_check(2, "dir_gap3");

      // Reload of one word from RUN writes address 0 again.
      set_stream(4, 1'b0, 0);
      load_and_check(1, "reload_run");

      zero_count("zero_from_run");
      zero_count("zero_from_err");

      // Timeout: two bytes then silence.
      set_stream(4, 1'b0, 0);
      clear_log();
      do_start(ADDR_W'(1), s);
      feed(2, stalls);
      err_edge = -1;
      for (int c = 0; c < 3 * TIMEOUT && err_edge < 0; c++) begin
         if (err === 1'b1) err_edge = edge_cnt;
         else @(negedge CLK);
      end
      // Last accept at edge s+2; err in cycle last+TIMEOUT+1.
      check("timeout_err_edge", 32'(err_edge), 32'(s + 2 + TIMEOUT));
      check("timeout_no_write", 32'(wr_addr_q.size()), 32'd0);
      check("timeout_core_rst", 32'(core_rst), 32'd1);
      set_stream(4, 1'b0, 2);
      load_and_check(1, "after_timeout");

      // Accept on the last cycle before expiry must win.
      set_stream(8, 1'b0, 1);
      gap_plan[1] = TIMEOUT - 1;
      gap_plan[6] = TIMEOUT - 1;
      load_and_check(2, "gap_limit");

      // Reset in the middle of the second word.
      set_stream(8, 1'b1, 0);
      clear_log();
      do_start(ADDR_W'(2), s);
      feed(5, stalls);
      check("midrst_word0_written", 32'(wr_addr_q.size()), 32'd1);
      #2 RST = 1'b1;
      #1 check_reset_values("mid_rst");
      @(negedge CLK);
      RST = 1'b0;
      set_stream(8, 1'b1, 0);
      load_and_check(2, "after_midrst");

      // Randomized loads.
      for (int t = 0; t < 8; t++) begin
         n_words = int'($urandom_range(1, 5));
         set_stream(4 * n_words, 1'b0, (t % 2 == 0) ? 0 : 4);
         load_and_check(n_words, "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/boot_loader.md
# boot_loader

Boot-time program loader that sits beside the single-cycle core `top`. It receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Each word is written into instruction memory through a dedicated write port. The core is held in reset until the whole program image is written; only then is the core released to fetch from address 0.

## Interface
- ADDR_W, 8: word-address width of the instruction-memory write port.
- TIMEOUT, 1024: number of consecutive receive cycles without an accepted byte before the load aborts. Must be ≥ 2.

- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle load request; samples word_count.
- word_count  in  ADDR_W  number of 32-bit words to load (1..2^ADDR_W-1).
- rx_valid  in  1  rx_data is valid.
- rx_data  in  8  stream byte.
- rx_ready  out  1  loader accepts a byte this cycle.
- we  out  1  instruction-memory write enable.
- waddr  out  ADDR_W  word write address.
- wdata  out  32  write data.
- core_rst  out  1  active-high reset to the core; high while not RUN.
- busy  out  1  load in progress (RECV or WRITE).
- done  out  1  program loaded; core running.
- err  out  1  load aborted (bad count or timeout).

## Operation
- State machine states: IDLE, RECV, WRITE, RUN, ERR.
- All outputs are registered or decoded directly from the state register, so they are glitch-free.
- A byte is accepted on a rising edge where rx_valid && rx_ready.
- rx_ready = 1 only in RECV.
- Byte assembly is little-endian:
  - 1st accepted byte → wdata[7:0]
  - 2nd → [15:8]
  - 3rd → [23:16]
  - 4th → [31:24]
- A 2-bit byte counter tracks position within the current word.
- IDLE:
  - start with word_count ≠ 0 → RECV; latch the count; word index := 0; byte counter := 0; timer := 0.
  - start with word_count = 0 → ERR.
- RECV:
  - On the 4th accepted byte → WRITE.
  - After TIMEOUT consecutive RECV cycles with no accept → ERR.
  - The timer clears on each accept and on entry to RECV.
- WRITE (exactly one cycle):
  - we = 1, waddr = word index, wdata = assembled word.
  - If word index = latched count − 1 → RUN; otherwise word index += 1 and → RECV.
- RUN:
  - core_rst = 0, done = 1.
  - start with word_count ≠ 0 → RECV (reload): core_rst reasserts in the same cycle as the transition, done clears.
  - start with word_count = 0 → ERR.
- ERR:
  - err = 1, core_rst = 1.
  - start with word_count ≠ 0 → RECV and err clears; otherwise the state holds.
- start is ignored in RECV and WRITE.
- busy = 1 in RECV or WRITE.
- Any byte presented outside RECV is not accepted, because rx_ready = 0.

## Timing
- Reset values: state IDLE, rx_ready 0, we 0, waddr 0, wdata 0, core_rst 1, busy 0, done 0, err 0, all counters 0.
- Asserting RST mid-load returns to IDLE immediately and discards the partial word. The memory contents already written are left untouched.
- start sampled at edge t → rx_ready = 1 in cycle t+1.
- The 4th byte accepted at edge t → we = 1 in cycle t+1 with the assembled wdata. rx_ready = 0 in that cycle.
- Minimum of 5 cycles per word at full rx_valid.
- N-word load with rx_valid continuously high: core_rst falls 5·N + 1 cycles after the start edge. It falls in the cycle after the last we pulse.
- waddr and wdata hold their last written value outside WRITE; we = 0 outside WRITE.
- The timer width is sized to reach TIMEOUT without wrap.
- With rx_valid = 0 in RECV, err rises in cycle TIMEOUT+1 after entry to RECV.
- An accept on the final timeout cycle wins over the timeout, and the timer clears.
- Word index wraps never: the count is limited to 2^ADDR_W − 1, so the index stays < 2^ADDR_W.

## Test plan
- Reset release, then start with word_count = 2 and bytes 13,01,10,00,33,03,03,00 with rx_valid held high → we pulses at waddr 0 with 00100113 and at waddr 1 with 00030333. core_rst falls 11 cycles after start; done = 1.
- Same stream but rx_valid dropped for 3 cycles between bytes 2 and 3 → identical words; we is delayed by 3 cycles; no err.
- start with word_count = 0 → err = 1 next cycle, core_rst stays 1, no we.
- TIMEOUT = 16, start with count 1, send 2 bytes then stop → err = 1 exactly 17 cycles after the last accept; no we; then start with count 1 and 4 bytes → err clears and done = 1.
- In RUN, pulse start with count 1 → core_rst = 1 and done = 0 next cycle; the reload writes waddr 0.
- RST asserted after 5 of 8 bytes → all outputs return to reset values asynchronously; a subsequent full load succeeds.
